// File: rtl/alu_pkg.sv
// Shared ALU definitions: multiplier FSM state encodings and scheduling constants.
package alu_pkg;

  // Multiplier FSM states; 2'b11 is illegal and recovers to IDLE.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  // Start-to-done latency of the multiply path, used by the result-mux scheduler.
  function automatic int MUL_LATENCY(input int size);
    return size + 32'sd1;
  endfunction

endpackage : alu_pkg

// File: rtl/fulladder_4.sv
// Parameterised ripple-carry adder: sum/carry_out = a + b + carry_in.
module fulladder_4 #(
  parameter int SIZE = 4
) (
  input  logic [SIZE-1:0] a,
  input  logic [SIZE-1:0] b,
  input  logic            carry_in,
  output logic [SIZE-1:0] sum,
  output logic            carry_out
);

  logic [SIZE:0] carry_s;

  assign carry_s[0] = carry_in;

  genvar i;
  generate
    for (i = 0; i < SIZE; i++) begin : g_bit
      assign sum[i]       = a[i] ^ b[i] ^ carry_s[i];
      assign carry_s[i+1] = (a[i] & b[i]) | (carry_s[i] & (a[i] ^ b[i]));
    end
  endgenerate

  assign carry_out = carry_s[SIZE];

endmodule : fulladder_4

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned shift-and-add multiplier: one ripple add and one right
// shift of {P_hi, M} per cycle; product registered on the final iteration.
module shift_add_multiplier
  import alu_pkg::*;
#(
  parameter int SIZE = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [SIZE-1:0]   a,
  input  logic [SIZE-1:0]   b,
  output logic              busy,
  output logic              done,
  output logic [2*SIZE-1:0] product
);

  localparam int                CNT_W    = $clog2(SIZE) + 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(SIZE - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

  state_t              state_r;
  state_t              state_next_s;
  logic [SIZE-1:0]     a_r;
  logic [SIZE-1:0]     m_r;
  logic [SIZE-1:0]     p_hi_r;
  logic [CNT_W-1:0]    cnt_r;
  logic [2*SIZE-1:0]   product_r;
  logic                busy_r;
  logic                done_r;

  logic [SIZE-1:0]     addend_s;
  logic [SIZE-1:0]     sum_s;
  logic                carry_s;
  logic [SIZE-1:0]     p_hi_next_s;
  logic [SIZE-1:0]     m_next_s;
  logic                last_iter_s;

  // Operand AND-mux: add the multiplicand only when the current multiplier bit is set.
  always_comb begin
    addend_s = {SIZE{1'b0}};
    if (m_r[0]) begin
      addend_s = a_r;
    end else begin
      addend_s = {SIZE{1'b0}};
    end
  end

  fulladder_4 #(.SIZE(SIZE)) u_adder (
    .a         (p_hi_r),
    .b         (addend_s),
    .carry_in  (1'b0),
    .sum       (sum_s),
    .carry_out (carry_s)
  );

  // The adder carry becomes the new top bit so no product bit is lost.
  assign p_hi_next_s = {carry_s, sum_s[SIZE-1:1]};
  assign m_next_s    = {sum_s[0], m_r[SIZE-1:1]};
  assign last_iter_s = (state_r == ST_RUN) && (cnt_r == CNT_LAST);

  // Next-state logic; any illegal encoding falls back to IDLE.
  always_comb begin
    state_next_s = ST_IDLE;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_next_s = ST_RUN;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (last_iter_s) begin
          state_next_s = ST_DONE;
        end else begin
          state_next_s = ST_RUN;
        end
      end
      ST_DONE: state_next_s = ST_IDLE;
      default: state_next_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Datapath registers: load operands on accepted start, shift-accumulate in RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r    <= {SIZE{1'b0}};
      m_r    <= {SIZE{1'b0}};
      p_hi_r <= {SIZE{1'b0}};
      cnt_r  <= {CNT_W{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            a_r    <= a;
            m_r    <= b;
            p_hi_r <= {SIZE{1'b0}};
            cnt_r  <= {CNT_W{1'b0}};
          end
        end
        ST_RUN: begin
          p_hi_r <= p_hi_next_s;
          m_r    <= m_next_s;
          cnt_r  <= cnt_r + CNT_ONE;
        end
        default: begin
          a_r    <= a_r;
          m_r    <= m_r;
          p_hi_r <= p_hi_r;
          cnt_r  <= cnt_r;
        end
      endcase
    end
  end

  // Product register: captures the post-shift {P_hi, M} on the final iteration only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      product_r <= {(2*SIZE){1'b0}};
    end else if (last_iter_s) begin
      product_r <= {p_hi_next_s, m_next_s};
    end
  end

  // Status flags registered from the next state so they align with RUN/DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      busy_r <= (state_next_s == ST_RUN);
      done_r <= (state_next_s == ST_DONE);
    end
  end

  assign busy    = busy_r;
  assign done    = done_r;
  assign product = product_r;

endmodule : shift_add_multiplier
